// File: rtl/uart_pkg.sv
// Shared definitions for the 8N1 serial link: receiver state encoding and
// frame geometry.
package uart_pkg;

  localparam int DATA_BITS      = 8;
  localparam int OVERSAMPLE_DEF = 16;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    START     = 3'd1,
    DATA      = 3'd2,
    STOP      = 3'd3,
    WAIT_HIGH = 3'd4
  } state_t;

endpackage

// File: rtl/uart_rx_8n1_if.sv
// Byte-level output side of the 8N1 receiver, plus its error flags.
interface uart_rx_8n1_if;

  // rxvalid rises with a new byte on rxbyte and holds, with rxbyte stable,
  // until a cycle where rxack=1; that cycle is the transfer. rxack is ignored
  // while rxvalid=0.
  logic [7:0] rxbyte;
  logic       rxvalid;
  logic       rxack;
  logic       overrun;
  logic       frame_err;

  modport master (
    output rxbyte,
    output rxvalid,
    output overrun,
    output frame_err,
    input  rxack
  );

  modport slave (
    input  rxbyte,
    input  rxvalid,
    input  overrun,
    input  frame_err,
    output rxack
  );

endinterface

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for an asynchronous single-bit input; the reset value
// is chosen per pin so the line's idle level is held through reset.
module sync_2ff #(
  parameter logic RESET_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= RESET_VAL;
      q    <= RESET_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/uart_rx_8n1.sv
// Receive-only 8N1 UART: oversampled start detection, mid-bit sampling, and a
// held valid/ack byte output with framing and overrun reporting.
module uart_rx_8n1
  import uart_pkg::*;
#(
  parameter int OVERSAMPLE = OVERSAMPLE_DEF
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 rx,
  output logic                 busy,
  output state_t               dbg_state,
  uart_rx_8n1_if.master        bus
);

  localparam int CW = $clog2(OVERSAMPLE);
  localparam logic [CW-1:0] CNT_HALF = CW'(OVERSAMPLE / 2 - 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(OVERSAMPLE - 1);
  localparam logic [2:0]    IDX_LAST = 3'(DATA_BITS - 1);

  logic rx_s;

  sync_2ff #(.RESET_VAL(1'b1)) u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (rx),
    .q     (rx_s)
  );

  state_t                 state, state_n;
  logic [CW-1:0]          cnt, cnt_n;
  logic [2:0]             idx, idx_n;
  logic [DATA_BITS-1:0]   shreg, shreg_n;
  logic [DATA_BITS-1:0]   rxbyte_q, rxbyte_n;
  logic                   rxvalid_q, rxvalid_n;
  logic                   overrun_q, overrun_n;
  logic                   frame_err_q, frame_err_n;
  logic                   byte_done;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      cnt         <= '0;
      idx         <= '0;
      shreg       <= '0;
      rxbyte_q    <= '0;
      rxvalid_q   <= 1'b0;
      overrun_q   <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      state       <= state_n;
      cnt         <= cnt_n;
      idx         <= idx_n;
      shreg       <= shreg_n;
      rxbyte_q    <= rxbyte_n;
      rxvalid_q   <= rxvalid_n;
      overrun_q   <= overrun_n;
      frame_err_q <= frame_err_n;
    end
  end

  always_comb begin
    state_n     = state;
    cnt_n       = cnt;
    idx_n       = idx;
    shreg_n     = shreg;
    rxbyte_n    = rxbyte_q;
    rxvalid_n   = rxvalid_q;
    overrun_n   = overrun_q;
    frame_err_n = 1'b0;
    byte_done   = 1'b0;

    if (rxvalid_q && bus.rxack) begin
      rxvalid_n = 1'b0;
      overrun_n = 1'b0;
    end

    case (state)
      IDLE: begin
        if (!rx_s) begin
          state_n = START;
          cnt_n   = '0;
        end
      end
      START: begin
        // Re-check the line half a bit in; a short low pulse is dropped silently.
        if (cnt == CNT_HALF) begin
          cnt_n = '0;
          idx_n = '0;
          if (!rx_s) state_n = DATA;
          else       state_n = IDLE;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      DATA: begin
        if (cnt == CNT_LAST) begin
          cnt_n   = '0;
          shreg_n = {rx_s, shreg[DATA_BITS-1:1]};
          idx_n   = idx + 3'd1;
          if (idx == IDX_LAST) state_n = STOP;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      STOP: begin
        if (cnt == CNT_LAST) begin
          cnt_n = '0;
          if (rx_s) begin
            state_n   = IDLE;
            byte_done = 1'b1;
          end else begin
            frame_err_n = 1'b1;
            state_n     = WAIT_HIGH;
          end
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      WAIT_HIGH: begin
        // Hold off until the line returns high so a break reports only once.
        if (rx_s) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase

    // A completing byte takes the output register if it is free or being
    // acknowledged this cycle; otherwise it is dropped and overrun latches.
    if (byte_done) begin
      if (!rxvalid_q || bus.rxack) begin
        rxbyte_n  = shreg;
        rxvalid_n = 1'b1;
        overrun_n = overrun_q;
      end else begin
        overrun_n = 1'b1;
      end
    end
  end

  assign busy          = (state != IDLE);
  assign dbg_state     = state;
  assign bus.rxbyte    = rxbyte_q;
  assign bus.rxvalid   = rxvalid_q;
  assign bus.overrun   = overrun_q;
  assign bus.frame_err = frame_err_q;

endmodule

// File: tb/tb_uart_rx_8n1.sv
// Directed bench for uart_rx_8n1: serial frames are driven on falling edges,
// outputs are checked on falling edges against hand-computed values.
module tb_uart_rx_8n1;
  import uart_pkg::*;

  logic   clk   = 1'b0;
  logic   rst_n = 1'b0;
  logic   rx    = 1'b1;
  logic   busy;
  state_t dbg_state;

  uart_rx_8n1_if bus ();

  uart_rx_8n1 #(.OVERSAMPLE(16)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .rx        (rx),
    .busy      (busy),
    .dbg_state (dbg_state),
    .bus       (bus.master)
  );

  always #5 clk = ~clk;

  int total  = 0;
  int bad    = 0;
  int fe_cnt = 0;
  int fe0;

  always @(posedge clk) if (bus.frame_err) fe_cnt++;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Called on a falling edge; the next rising edge is edge 0 of the frame.
  // Returns on the falling edge before edge 144 with the stop level on rx.
  task automatic drive_frame(input logic [7:0] d, input logic stop);
    rx = 1'b0;
    tick(16);
    for (int i = 0; i < 8; i++) begin
      rx = d[i];
      tick(16);
    end
    rx = stop;
  endtask

  // Stop sample lands on edge 154; returns on the falling edge before edge 160.
  task automatic finish_ok(input string tag, input logic [7:0] exp_byte);
    tick(10);
    check({tag, "_busy_pre"}, busy, 1);
    check({tag, "_valid_pre"}, bus.rxvalid, 0);
    tick(1);
    check({tag, "_valid"}, bus.rxvalid, 1);
    check({tag, "_byte"}, bus.rxbyte, exp_byte);
    check({tag, "_ferr"}, bus.frame_err, 0);
    check({tag, "_busy_post"}, busy, 0);
    tick(5);
  endtask

  task automatic ack_pulse();
    bus.rxack = 1'b1;
    tick(1);
    bus.rxack = 1'b0;
  endtask

  initial begin
    bus.rxack = 1'b0;
    tick(3);
    check("rst_valid", bus.rxvalid, 0);
    check("rst_byte", bus.rxbyte, 8'h00);
    check("rst_overrun", bus.overrun, 0);
    check("rst_ferr", bus.frame_err, 0);
    check("rst_busy", busy, 0);
    check("rst_state", dbg_state, IDLE);
    rst_n = 1'b1;
    tick(3);

    // 1: clean frame 0xA5
    drive_frame(8'hA5, 1'b1);
    finish_ok("t1", 8'hA5);
    ack_pulse();
    check("t1_ack_valid", bus.rxvalid, 0);

    // 2: 4-cycle glitch is rejected at the half-bit check
    fe0 = fe_cnt;
    rx = 1'b0;
    tick(4);
    rx = 1'b1;
    check("t2_busy_start", busy, 1);
    tick(8);
    check("t2_busy_abort", busy, 0);
    check("t2_valid", bus.rxvalid, 0);
    check("t2_ferr_cnt", fe_cnt - fe0, 0);
    tick(10);

    // 3: stop bit low for 40 clk, then recovery with 0x55
    fe0 = fe_cnt;
    drive_frame(8'h3C, 1'b0);
    tick(10);
    check("t3_ferr_pre", bus.frame_err, 0);
    tick(1);
    check("t3_ferr", bus.frame_err, 1);
    check("t3_valid", bus.rxvalid, 0);
    check("t3_busy", busy, 1);
    tick(1);
    check("t3_ferr_fall", bus.frame_err, 0);
    tick(28);
    check("t3_busy_wait", busy, 1);
    check("t3_state_wait", dbg_state, WAIT_HIGH);
    rx = 1'b1;
    tick(4);
    check("t3_busy_idle", busy, 0);
    check("t3_ferr_cnt", fe_cnt - fe0, 1);
    tick(10);
    drive_frame(8'h55, 1'b1);
    finish_ok("t3b", 8'h55);
    ack_pulse();

    // 4: back-to-back 0x00 and 0xFF without ack -> overrun
    drive_frame(8'h00, 1'b1);
    finish_ok("t4a", 8'h00);
    check("t4a_overrun", bus.overrun, 0);
    drive_frame(8'hFF, 1'b1);
    tick(11);
    check("t4_byte_kept", bus.rxbyte, 8'h00);
    check("t4_valid", bus.rxvalid, 1);
    check("t4_overrun", bus.overrun, 1);
    tick(5);
    ack_pulse();
    check("t4_ack_valid", bus.rxvalid, 0);
    check("t4_ack_overrun", bus.overrun, 0);
    ack_pulse();
    check("t4_idle_ack", bus.rxvalid, 0);

    // 5: ack coincides with the second stop sample
    drive_frame(8'h12, 1'b1);
    finish_ok("t5a", 8'h12);
    drive_frame(8'h34, 1'b1);
    tick(10);
    bus.rxack = 1'b1;
    tick(1);
    bus.rxack = 1'b0;
    check("t5_byte", bus.rxbyte, 8'h34);
    check("t5_valid", bus.rxvalid, 1);
    check("t5_overrun", bus.overrun, 0);
    tick(5);

    // 6: reset during data bit 4 of 0xC3, then 0x81
    rx = 1'b0;
    tick(16);
    for (int i = 0; i < 4; i++) begin
      rx = (i < 2) ? 1'b1 : 1'b0;
      tick(16);
    end
    rx = 1'b0;
    tick(8);
    check("t6_busy_mid", busy, 1);
    rst_n = 1'b0;
    rx    = 1'b1;
    #1;
    check("t6_rst_valid", bus.rxvalid, 0);
    check("t6_rst_byte", bus.rxbyte, 8'h00);
    check("t6_rst_busy", busy, 0);
    check("t6_rst_overrun", bus.overrun, 0);
    tick(2);
    rst_n = 1'b1;
    tick(20);
    check("t6_idle_valid", bus.rxvalid, 0);
    check("t6_idle_busy", busy, 0);
    drive_frame(8'h81, 1'b1);
    finish_ok("t6", 8'h81);
    ack_pulse();
    check("t6_ack_valid", bus.rxvalid, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
